// File: rtl/aes_stream_pkg.sv
// Shared types for the AES streaming front-end.
// Mode encodings, controller states and counter helper.
package aes_stream_pkg;

  localparam int AES_BLK_W = 128;
  localparam int AES_KEY_W = 256;

  typedef enum logic [1:0] {
    MODE_ECB_ENC = 2'd0,
    MODE_ECB_DEC = 2'd1,
    MODE_CTR     = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KINIT,
    ST_KWAIT,
    ST_READY,
    ST_ISSUE,
    ST_BWAIT,
    ST_HOLD
  } state_e;

  // Only the low w bits count; the carry never reaches the upper bits.
  function automatic logic [AES_BLK_W-1:0] ctr_inc(
    input logic [AES_BLK_W-1:0] c,
    input int                   w
  );
    logic [AES_BLK_W-1:0] m;
    if (w >= AES_BLK_W) m = '1;
    else m = (AES_BLK_W'(1) << w) - AES_BLK_W'(1);
    return (c & ~m) | ((c + AES_BLK_W'(1)) & m);
  endfunction

endpackage

// File: rtl/aes_stream_ctrl_fifo.sv
// Input block FIFO: data plus last flag per entry.
// Registered count drives full/empty.
module aes_blk_fifo #(
  parameter int W     = 129,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [W-1:0]               wdata_i,
  input  logic                       pop_i,
  output logic [W-1:0]               rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop) rptr_q <= rptr_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/aes_stream_ctrl.sv
// Streaming ECB/CTR front-end that sequences an external AES core.
// Blocks are buffered, issued one at a time and returned in order.
module aes_stream_ctrl
  import aes_stream_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CTR_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [AES_KEY_W-1:0] cfg_key,
  input  logic                 cfg_keylen,
  input  logic [1:0]           cfg_mode,
  input  logic [AES_BLK_W-1:0] cfg_iv,
  input  logic                 cfg_start,
  output logic                 cfg_busy,
  output logic                 cfg_err,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [AES_BLK_W-1:0] in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [AES_BLK_W-1:0] out_data,
  output logic                 out_last,
  output logic                 core_encdec,
  output logic                 core_init,
  output logic                 core_next,
  input  logic                 core_ready,
  output logic [AES_KEY_W-1:0] core_key,
  output logic                 core_keylen,
  output logic [AES_BLK_W-1:0] core_block,
  input  logic [AES_BLK_W-1:0] core_result,
  input  logic                 core_result_valid
);

  state_e               state_q;
  mode_e                mode_q;
  logic [AES_KEY_W-1:0] key_q;
  logic                 keylen_q;
  logic [AES_BLK_W-1:0] counter_q;
  logic [AES_BLK_W-1:0] data_q;
  logic                 last_q;
  logic                 guard_q;
  logic                 key_loaded_q;
  logic                 cfg_err_q;
  logic                 core_init_q;
  logic                 core_next_q;
  logic                 core_encdec_q;
  logic [AES_BLK_W-1:0] core_block_q;
  logic                 out_valid_q;
  logic [AES_BLK_W-1:0] out_data_q;
  logic                 out_last_q;

  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   fifo_push;
  logic                   fifo_pop;
  logic [AES_BLK_W:0]     fifo_rdata;
  logic [$clog2(FIFO_DEPTH):0] unused_cnt;
  logic                   unused_rv;
  logic                   start_ok;

  assign unused_rv = core_result_valid;

  assign in_ready  = !fifo_full;
  assign fifo_push = in_valid && !fifo_full;
  assign fifo_pop  = (state_q == ST_READY) && !fifo_empty
                     && key_loaded_q;

  assign cfg_busy = !(state_q inside {ST_IDLE, ST_READY})
                    || !fifo_empty || out_valid_q;
  assign start_ok = cfg_start && !cfg_busy;

  assign cfg_err     = cfg_err_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_last    = out_last_q;
  assign core_encdec = core_encdec_q;
  assign core_init   = core_init_q;
  assign core_next   = core_next_q;
  assign core_key    = key_q;
  assign core_keylen = keylen_q;
  assign core_block  = core_block_q;

  aes_blk_fifo #(
    .W     (AES_BLK_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .push_i  (fifo_push),
    .wdata_i ({in_last, in_data}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (unused_cnt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      mode_q        <= MODE_ECB_ENC;
      key_q         <= '0;
      keylen_q      <= 1'b0;
      counter_q     <= '0;
      data_q        <= '0;
      last_q        <= 1'b0;
      guard_q       <= 1'b0;
      key_loaded_q  <= 1'b0;
      cfg_err_q     <= 1'b0;
      core_init_q   <= 1'b0;
      core_next_q   <= 1'b0;
      core_encdec_q <= 1'b0;
      core_block_q  <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_last_q    <= 1'b0;
    end else begin
      core_init_q <= 1'b0;
      core_next_q <= 1'b0;
      unique case (state_q)
        ST_IDLE, ST_READY: begin
          if (start_ok && cfg_mode == MODE_RSVD) begin
            cfg_err_q <= 1'b1;
          end else if (start_ok) begin
            key_q        <= cfg_key;
            keylen_q     <= cfg_keylen;
            mode_q       <= mode_e'(cfg_mode);
            counter_q    <= cfg_iv;
            cfg_err_q    <= 1'b0;
            key_loaded_q <= 1'b0;
            state_q      <= ST_KINIT;
          end else if (fifo_pop) begin
            data_q  <= fifo_rdata[AES_BLK_W-1:0];
            last_q  <= fifo_rdata[AES_BLK_W];
            state_q <= ST_ISSUE;
          end
        end
        ST_KINIT: begin
          if (core_ready) begin
            core_init_q   <= 1'b1;
            core_encdec_q <= 1'b1;
            guard_q       <= 1'b0;
            state_q       <= ST_KWAIT;
          end
        end
        // Guard cycle lets the core drop ready after the pulse.
        ST_KWAIT: begin
          if (!guard_q) begin
            guard_q <= 1'b1;
          end else if (core_ready) begin
            key_loaded_q <= 1'b1;
            state_q      <= ST_READY;
          end
        end
        ST_ISSUE: begin
          core_block_q  <= (mode_q == MODE_CTR) ? counter_q : data_q;
          core_encdec_q <= (mode_q != MODE_ECB_DEC);
          core_next_q   <= 1'b1;
          guard_q       <= 1'b0;
          state_q       <= ST_BWAIT;
        end
        ST_BWAIT: begin
          if (!guard_q) begin
            guard_q <= 1'b1;
          end else if (core_ready) begin
            out_data_q  <= (mode_q == MODE_CTR) ? (core_result ^ data_q)
                                                : core_result;
            out_last_q  <= last_q;
            out_valid_q <= 1'b1;
            if (mode_q == MODE_CTR)
              counter_q <= ctr_inc(counter_q, CTR_WIDTH);
            state_q <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_READY;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_stream_ctrl.sv
// Directed bench for aes_stream_ctrl with a lookup-table AES core model.
// Known FIPS-197/SP800-38A vectors are served; other blocks use a keyed XOR.
module tb_aes_stream_ctrl;

  localparam int LAT = 6;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [255:0] cfg_key;
  logic         cfg_keylen;
  logic [1:0]   cfg_mode;
  logic [127:0] cfg_iv;
  logic         cfg_start;
  logic         cfg_busy;
  logic         cfg_err;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         out_last;
  logic         core_encdec;
  logic         core_init;
  logic         core_next;
  logic         core_ready;
  logic [255:0] core_key;
  logic         core_keylen;
  logic [127:0] core_block;
  logic [127:0] core_result;
  logic         core_result_valid;

  int errors = 0;
  int checks = 0;

  localparam logic [255:0] K128 =
    256'h000102030405060708090a0b0c0d0e0f_00000000000000000000000000000000;
  localparam logic [255:0] K256 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KCTR =
    256'h2b7e151628aed2a6abf7158809cf4f3c_00000000000000000000000000000000;
  localparam logic [255:0] KX =
    256'h5a5a00ff33cc0f0f123456789abcdef0_00000000000000000000000000000000;

  always #5 clk = ~clk;

  aes_stream_ctrl #(.FIFO_DEPTH(4), .CTR_WIDTH(32)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .cfg_key           (cfg_key),
    .cfg_keylen        (cfg_keylen),
    .cfg_mode          (cfg_mode),
    .cfg_iv            (cfg_iv),
    .cfg_start         (cfg_start),
    .cfg_busy          (cfg_busy),
    .cfg_err           (cfg_err),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_data           (in_data),
    .in_last           (in_last),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_data          (out_data),
    .out_last          (out_last),
    .core_encdec       (core_encdec),
    .core_init         (core_init),
    .core_next         (core_next),
    .core_ready        (core_ready),
    .core_key          (core_key),
    .core_keylen       (core_keylen),
    .core_block        (core_block),
    .core_result       (core_result),
    .core_result_valid (core_result_valid)
  );

  function automatic logic [127:0] aes_lut(
    input logic [255:0] k, input logic kl,
    input logic enc, input logic [127:0] b
  );
    if (enc && !kl && k == K128
        && b == 128'h00112233445566778899aabbccddeeff)
      return 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    if (!enc && kl && k == K256
        && b == 128'h8ea2b7ca516745bfeafc49904b496089)
      return 128'h00112233445566778899aabbccddeeff;
    if (enc && !kl && k == KCTR
        && b == 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff)
      return 128'hec8cdf7398607cb0f2d21675ea9ea1e4;
    if (enc && !kl && k == KCTR
        && b == 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00)
      return 128'h362b7c3c6773516318a077d7fc5073ae;
    return b ^ k[255:128] ^ {128{~enc}};
  endfunction

  logic [255:0] mk;
  logic         mkl;
  logic [127:0] pend;
  int           cnt;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      core_ready        <= 1'b1;
      core_result       <= '0;
      core_result_valid <= 1'b0;
      cnt               <= 0;
      mk                <= '0;
      mkl               <= 1'b0;
      pend              <= '0;
    end else begin
      core_result_valid <= 1'b0;
      if (cnt != 0) begin
        cnt <= cnt - 1;
        if (cnt == 1) begin
          core_ready        <= 1'b1;
          core_result       <= pend;
          core_result_valid <= 1'b1;
        end
      end else if (core_init) begin
        mk         <= core_key;
        mkl        <= core_keylen;
        core_ready <= 1'b0;
        cnt        <= LAT;
      end else if (core_next) begin
        pend       <= aes_lut(mk, mkl, core_encdec, core_block);
        core_ready <= 1'b0;
        cnt        <= LAT;
      end
    end
  end

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [1:0] m, input logic kl,
                       input logic [255:0] k, input logic [127:0] iv);
    cfg_mode = m; cfg_keylen = kl; cfg_key = k; cfg_iv = iv;
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    while (cfg_busy && t < 300) begin @(negedge clk); t++; end
    chk(tag, cfg_busy, 0);
  endtask

  task automatic send(input logic [127:0] d, input logic l);
    int t = 0;
    in_data = d; in_last = l; in_valid = 1'b1;
    while (!in_ready && t < 300) begin @(negedge clk); t++; end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic push_n(input int total, input int budget,
                        output int acc);
    acc = 0;
    for (int c = 0; c < budget && acc < total; c++) begin
      in_valid = 1'b1;
      in_data  = 128'(acc + 1) * 128'h11111111111111111111111111111111;
      in_last  = (acc == 4);
      if (in_ready) acc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic recv(input logic [127:0] ed, input logic el,
                      input string tag);
    int t = 0;
    while (!out_valid && t < 300) begin @(negedge clk); t++; end
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_data"}, out_data, ed);
    chk({tag, "_last"}, out_last, el);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    int acc;
    int bad;
    logic [127:0] b;
    reset_n = 1'b0; cfg_key = '0; cfg_keylen = 1'b0; cfg_mode = 2'd0;
    cfg_iv = '0; cfg_start = 1'b0; in_valid = 1'b0; in_data = '0;
    in_last = 1'b0; out_ready = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", cfg_busy, 0);
    chk("rst_err", cfg_err, 0);
    chk("rst_core_key", core_key, 0);
    chk("rst_core_init", core_init, 0);
    chk("rst_core_encdec", core_encdec, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    start(2'd0, 1'b0, K128, '0);
    chk("t1_busy_kinit", cfg_busy, 1);
    wait_idle("t1_idle");
    send(128'h00112233445566778899aabbccddeeff, 1'b0);
    recv(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b0, "t1_ecb_enc");

    wait_idle("t2_idle0");
    start(2'd1, 1'b1, K256, '0);
    wait_idle("t2_idle");
    chk("t2_keylen", core_keylen, 1);
    send(128'h8ea2b7ca516745bfeafc49904b496089, 1'b1);
    recv(128'h00112233445566778899aabbccddeeff, 1'b1, "t2_ecb_dec");

    wait_idle("t3_idle0");
    start(2'd2, 1'b0, KCTR, 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff);
    wait_idle("t3_idle");
    send(128'h6bc1bee22e409f96e93d7e117393172a, 1'b0);
    send(128'hae2d8a571e03ac9c9eb76fac45af8e51, 1'b1);
    recv(128'h874d6191b620e3261bef6864990db6ce, 1'b0, "t3_ctr0");
    recv(128'h9806f66b7970fdff8617187bb9fffdff, 1'b1, "t3_ctr1");

    wait_idle("t4_idle0");
    start(2'd2, 1'b0, '0, 128'h0123456789abcdef_00000001_ffffffff);
    wait_idle("t4_idle");
    send('0, 1'b1);
    send('0, 1'b0);
    recv(128'h0123456789abcdef_00000001_ffffffff, 1'b1, "t4_ctr0");
    recv(128'h0123456789abcdef_00000001_00000000, 1'b0, "t4_wrap");

    wait_idle("t5_idle0");
    start(2'd0, 1'b0, KX, '0);
    wait_idle("t5_idle");
    push_n(7, 40, acc);
    chk("t5_accepted", 32'(acc), 5);
    chk("t5_in_ready", in_ready, 0);
    chk("t5_busy", cfg_busy, 1);
    b = 128'h11111111111111111111111111111111 ^ KX[255:128];
    chk("t5_hold_d0", out_data, b);
    start(2'd3, 1'b0, KX, '0);
    repeat (3) @(negedge clk);
    chk("t5_hold_d1", out_data, b);
    chk("t5_drop_err", cfg_err, 0);
    for (int i = 1; i <= 5; i++) begin
      b = 128'(i) * 128'h11111111111111111111111111111111;
      recv(b ^ KX[255:128], (i == 5), $sformatf("t5_blk%0d", i));
    end
    chk("t5_in_ready_back", in_ready, 1);

    wait_idle("t6_idle0");
    start(2'd0, 1'b0, KX, '0);
    wait_idle("t6_idle");
    push_n(4, 20, acc);
    chk("t6_accepted", 32'(acc), 4);
    chk("t6_not_done", out_valid, 0);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_in_ready", in_ready, 1);
    chk("t6_rst_busy", cfg_busy, 0);
    chk("t6_rst_block", core_block, 0);
    chk("t6_rst_key", core_key, 0);
    chk("t6_rst_next", core_next, 0);
    @(negedge clk);
    reset_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (out_valid || core_next || core_init) bad++;
    end
    chk("t6_no_activity", 32'(bad), 0);
    start(2'd3, 1'b0, KX, '0);
    chk("t6_err_set", cfg_err, 1);
    chk("t6_err_stay", cfg_busy, 0);
    start(2'd1, 1'b0, KX, '0);
    chk("t6_err_clr", cfg_err, 0);
    wait_idle("t6_idle2");
    b = 128'hcafef00d_00000000_deadbeef_01234567;
    send(b, 1'b1);
    recv(b ^ KX[255:128] ^ {128{1'b1}}, 1'b1, "t6_dec");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_stream_ctrl.md
Name: aes_stream_ctrl

Overview:
- Streaming front-end for the AES core: accepts a valid/ready stream of 128-bit blocks, buffers it in a FIFO and sequences key init and per-block next on the core.
- Returns results on an output valid/ready stream.
- Adds ECB-encrypt, ECB-decrypt and CTR modes with a parametrised counter, so software no longer hand-drives init/next per block.
- Sits between the accelerator's bus/DMA front-end and one external AES core instance.

Parameters:
FIFO_DEPTH, 4, input block FIFO depth (power of two, ≥2)
CTR_WIDTH, 32, low bits of counter block incremented in CTR mode (1..128)

Ports:
clk  in  1  system clock
reset_n  in  1  reset, asynchronous active-low
cfg_key  in  256  key; AES-128 uses bits [255:128]
cfg_keylen  in  1  0=128-bit, 1=256-bit key
cfg_mode  in  2  0=ECB enc, 1=ECB dec, 2=CTR, 3=reserved
cfg_iv  in  128  initial counter block (CTR)
cfg_start  in  1  one-cycle pulse: latch cfg_*, run key init
cfg_busy  out  1  start ignored while high
cfg_err  out  1  sticky: start with mode 3; cleared by next accepted start
in_valid/in_ready  in/out  1  input handshake
in_data  in  128  input block
in_last  in  1  last block of message
out_valid/out_ready  out/in  1  output handshake
out_data  out  128  result block
out_last  out  1  in_last of the source block
core_encdec  out  1  to core (1=encrypt)
core_init  out  1  to core, one-cycle pulse
core_next  out  1  to core, one-cycle pulse
core_ready  in  1  from core
core_key  out  256  to core
core_keylen  out  1  to core
core_block  out  128  to core
core_result  in  128  from core
core_result_valid  in  1  from core (unused beyond debug)

Behaviour:
- Reset values: all outputs 0, except in_ready=1. FIFO empty, key_loaded=0, counter=0, state IDLE.
- in_ready = !fifo_full, independent of state. A push happens on in_valid&in_ready.
- FSM states: IDLE, KINIT, KWAIT, READY, ISSUE, BWAIT, HOLD.
- IDLE: on cfg_start with mode≠3, latch key, keylen, mode and iv into registers, then go to KINIT. Mode 3 sets cfg_err and stays put.
- KINIT: wait for core_ready=1, then pulse core_init for one cycle with core_encdec=1, then go to KWAIT.
- KWAIT: skip one guard cycle, then wait for core_ready=1. Then set key_loaded=1 and go to READY.
- READY: if FIFO is not empty, pop the head into a working register (data, last) and go to ISSUE. cfg_start is accepted here only when FIFO is empty and out_valid=0, and goes to KINIT.
- ISSUE:
  - ECB: core_block = data; core_encdec = (mode==0).
  - CTR: core_block = counter; core_encdec = 1.
  - Pulse core_next for one cycle, then go to BWAIT.
- BWAIT: skip one guard cycle, then wait for core_ready=1.
  - ECB: out_data = core_result.
  - CTR: out_data = core_result ^ data.
  - Set out_valid=1 and out_last=last, then go to HOLD.
  - CTR: counter[CTR_WIDTH-1:0] increments modulo 2^CTR_WIDTH; the upper bits never change.
- HOLD: on out_ready, clear out_valid and return to READY.
  - out_data and out_last stay stable while out_valid=1 && !out_ready.
- Latency, FIFO non-empty in READY to out_valid: 4 cycles plus the core processing time.
- in_last does not reset the counter or the key; only cfg_start reloads the counter from IV.
- cfg_busy = (state∉{IDLE,READY}) | !fifo_empty | out_valid.
- A cfg_start that is not accepted is dropped; it is not queued.
- Simultaneous push and pop on a full FIFO are legal: the pop frees the slot, in_ready is computed from the registered count, and the push is refused that cycle.
- Reset mid-operation: asynchronous return to reset values. In-flight and buffered blocks are discarded; the core is re-initialised by its own reset.

Decomposition:
- Package aes_stream_pkg:
  - mode encodings (MODE_ECB_ENC, MODE_ECB_DEC, MODE_CTR)
  - FSM state enum
  - AES_BLK_W=128, AES_KEY_W=256
- Sub-module aes_blk_fifo: synchronous FIFO, width 129 (data+last), depth FIFO_DEPTH, with full/empty/count outputs.

Test Plan:
1. ECB enc, keylen=0, key 000102…0f, block 00112233445566778899aabbccddeeff -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a.
2. ECB dec, keylen=1, key 00…1f, block 8ea2b7ca516745bfeafc49904b496089 -> out_data 00112233445566778899aabbccddeeff.
3. CTR, key 2b7e151628aed2a6abf7158809cf4f3c, IV f0f1f2…feff, block 6bc1bee22e409f96e93d7e117393172a -> 874d6191b620e3261bef6864990db6ce. Second block ae2d8a571e03ac9c9eb76fac45af8e51 -> 9806f66b7970fdff8617187bb9fffdff.
4. CTR wrap, CTR_WIDTH=32, IV 0x…_00000001_ffffffff -> second block uses counter …_00000001_00000000; upper 96 bits unchanged.
5. Backpressure, FIFO_DEPTH=4, out_ready=0, push 7 blocks:
   - in_ready drops after the 5th accept (1 in HOLD, 4 in FIFO).
   - Releasing out_ready delivers all 5 in order, with out_last on block 5 when set.
6. Reset asserted in BWAIT with 3 blocks queued -> outputs immediately 0 and in_ready=1. After release, cfg_start is required before any output, and a mode=3 start sets cfg_err.
